// File: rtl/async_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : async_sram_ctrl_pkg
// Purpose  : Shared state encoding and counter sizing helpers for the
//            asynchronous SRAM controller.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package async_sram_ctrl_pkg;

    // Controller states: idle, read strobe, write strobe, write hold, bus turnaround
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WHOLD = 3'd3,
        ST_TURN  = 3'd4
    } state_t;

    // Number of bits needed to hold max_val, never less than one
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/async_sram_ctrl_iobuf.sv
`default_nettype none
// ============================================================================
// Module   : sram_iobuf
// Purpose  : DATA_W-wide bidirectional pad buffer with registered output
//            enable and output data, plus a raw input path to the capture reg.
// Revision : 1.0 - initial release
// ============================================================================
module sram_iobuf #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              drive_next,
    input  logic              load,
    input  logic [DATA_W-1:0] dout_next,
    output logic [DATA_W-1:0] din,
    inout  wire  [DATA_W-1:0] pad
);

    logic              drive;
    logic [DATA_W-1:0] dout;

    // Output enable follows the controller every cycle; data is held until reloaded
    always_ff @(posedge clock) begin
        if (rst) begin
            drive <= 1'b0;
            dout  <= '0;
        end else begin
            drive <= drive_next;
            if (load) dout <= dout_next;
        end
    end

    assign pad = drive ? dout : {DATA_W{1'bz}};
    assign din = pad;

endmodule
`default_nettype wire

// File: rtl/async_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : async_sram_ctrl
// Purpose  : Bridges the mem_* request/response port to ganged asynchronous
//            SRAM chips with configurable wait states and bus turnaround.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module async_sram_ctrl
    import async_sram_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 18,
    parameter int ID_W       = 2,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1,
    parameter int TURNAROUND = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    output logic                  mem_waitrequest,
    input  logic [ID_W-1:0]       mem_id,
    input  logic [29:0]           mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W/8-1:0]   mem_writedatamask,
    output logic [DATA_W-1:0]     mem_readdata,
    output logic [ID_W-1:0]       mem_readdataid,
    output logic [ADDR_W-1:0]     sram_a,
    inout  wire  [DATA_W-1:0]     sram_d,
    output logic                  sram_cs_n,
    output logic [DATA_W/8-1:0]   sram_be_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = cnt_width(max3(READ_WAIT, WRITE_WAIT, TURNAROUND));

    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WAIT);
    // TURN is entered for TURNAROUND cycles, so the count starts one lower
    localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [ADDR_W-1:0]   a_nx;
    logic                cs_nx, oe_nx, we_nx;
    logic [BE_W-1:0]     be_nx;
    logic [ID_W-1:0]     id_q, id_nx;
    logic [DATA_W-1:0]   rdata_nx;
    logic [ID_W-1:0]     rid_nx;
    logic                wr_load;
    logic                drive_nx;
    logic [DATA_W-1:0]   din;

    // Address bits above the SRAM width alias onto the same word
    generate
        if (ADDR_W < 30) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_address[29:ADDR_W];
        end
    endgenerate

    assign mem_waitrequest = rst | (state != ST_IDLE);
    // Data bus is ours only while the write strobe and its hold cycle run
    assign drive_nx = (state_nx == ST_WRITE) || (state_nx == ST_WHOLD);

    sram_iobuf #(
        .DATA_W (DATA_W)
    ) u_iobuf (
        .clock      (clock),
        .rst        (rst),
        .drive_next (drive_nx),
        .load       (wr_load),
        .dout_next  (mem_writedata),
        .din        (din),
        .pad        (sram_d)
    );

    // State register and all registered pin / response outputs
    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            sram_a         <= '0;
            sram_cs_n      <= 1'b1;
            sram_oe_n      <= 1'b1;
            sram_we_n      <= 1'b1;
            sram_be_n      <= '1;
            id_q           <= '0;
            mem_readdata   <= '0;
            mem_readdataid <= '0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            sram_a         <= a_nx;
            sram_cs_n      <= cs_nx;
            sram_oe_n      <= oe_nx;
            sram_we_n      <= we_nx;
            sram_be_n      <= be_nx;
            id_q           <= id_nx;
            mem_readdata   <= rdata_nx;
            mem_readdataid <= rid_nx;
        end
    end

    // Next-state and next-output decode; outputs hold unless a state changes them
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_nx     = sram_a;
        cs_nx    = sram_cs_n;
        oe_nx    = sram_oe_n;
        we_nx    = sram_we_n;
        be_nx    = sram_be_n;
        id_nx    = id_q;
        rdata_nx = mem_readdata;
        rid_nx   = '0;
        wr_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Write wins when both strobes arrive together
                if (mem_write) begin
                    a_nx     = mem_address[ADDR_W-1:0];
                    be_nx    = ~mem_writedatamask;
                    cs_nx    = 1'b0;
                    we_nx    = 1'b0;
                    cnt_nx   = WRITE_LOAD;
                    wr_load  = 1'b1;
                    state_nx = ST_WRITE;
                end else if (mem_read) begin
                    a_nx     = mem_address[ADDR_W-1:0];
                    id_nx    = mem_id;
                    be_nx    = '0;
                    cs_nx    = 1'b0;
                    oe_nx    = 1'b0;
                    cnt_nx   = READ_LOAD;
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_ONE;
                end else begin
                    rdata_nx = din;
                    rid_nx   = id_q;
                    cs_nx    = 1'b1;
                    oe_nx    = 1'b1;
                    be_nx    = '1;
                    if (TURNAROUND > 0) begin
                        cnt_nx   = TURN_LOAD;
                        state_nx = ST_TURN;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_ONE;
                end else begin
                    we_nx    = 1'b1;
                    state_nx = ST_WHOLD;
                end
            end
            ST_WHOLD: begin
                cs_nx    = 1'b1;
                be_nx    = '1;
                state_nx = ST_IDLE;
            end
            ST_TURN: begin
                if (cnt != '0) cnt_nx = cnt - CNT_ONE;
                else           state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
